concat_stream: RTL

CONCAT_STREAM -- requirements
Module: concat_stream

---
 rtl/concat_stream.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/concat_stream.sv
// concat_stream: pairs words from two independent valid/ready input streams
// and emits them as one concatenated word on a valid/ready output.
//
// Each input channel has its own DEPTH-entry FIFO. When both FIFOs hold a word
// and the output register is free (or being drained this cycle), one word is
// popped from each and registered as a pair. Pairing is strictly in order.
//
// Parameters:
//   WIDTH     - bit width of each input word
//   DEPTH     - entries per input FIFO (power of two, >= 2)
//   FEAT_HIGH - 1: {feature, context2}; 0: {context2, feature}
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   feat_valid/feat_ready - feature handshake, word on feature
//   ctx_valid/ctx_ready   - context handshake, word on context2
//   out_valid/out_ready   - output handshake, pair on concat_out
//   pair_count            - output-handshake counter (only with
//                           CONCAT_STREAM_STATS_EN defined)
//
// Optional feature macro: CONCAT_STREAM_STATS_EN
module concat_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FEAT_HIGH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               feat_valid,
  output logic               feat_ready,
  input  logic [WIDTH-1:0]   feature,
  input  logic               ctx_valid,
  output logic               ctx_ready,
  input  logic [WIDTH-1:0]   context2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] concat_out
`ifdef CONCAT_STREAM_STATS_EN
  ,
  output logic [15:0]        pair_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned OW = 2 * WIDTH;

  // FIFO storage and pointers (one extra pointer bit separates full from empty)
  logic [WIDTH-1:0] feat_mem_q [DEPTH];
  logic [WIDTH-1:0] ctx_mem_q  [DEPTH];
  logic [PW-1:0]    feat_wr_q, feat_wr_d, feat_rd_q, feat_rd_d;
  logic [PW-1:0]    ctx_wr_q,  ctx_wr_d,  ctx_rd_q,  ctx_rd_d;

  logic             feat_empty, feat_full, ctx_empty, ctx_full;
  logic             feat_push, ctx_push, pair_load;
  logic [WIDTH-1:0] feat_head, ctx_head;

  logic             out_valid_q, out_valid_d;
  logic [OW-1:0]    concat_q, concat_d;

  // Occupancy status from registered pointers only
  always_comb begin
    feat_empty = (feat_wr_q == feat_rd_q);
    feat_full  = (feat_wr_q[AW] != feat_rd_q[AW]) &&
                 (feat_wr_q[AW-1:0] == feat_rd_q[AW-1:0]);
    ctx_empty  = (ctx_wr_q == ctx_rd_q);
    ctx_full   = (ctx_wr_q[AW] != ctx_rd_q[AW]) &&
                 (ctx_wr_q[AW-1:0] == ctx_rd_q[AW-1:0]);
  end

  assign feat_ready = !feat_full;
  assign ctx_ready  = !ctx_full;
  assign out_valid  = out_valid_q;
  assign concat_out = concat_q;

  assign feat_head = feat_mem_q[feat_rd_q[AW-1:0]];
  assign ctx_head  = ctx_mem_q[ctx_rd_q[AW-1:0]];

  // Handshakes: load a pair when both heads exist and the output slot frees up
  always_comb begin
    feat_push = feat_valid && !feat_full;
    ctx_push  = ctx_valid && !ctx_full;
    pair_load = !feat_empty && !ctx_empty && (!out_valid_q || out_ready);
  end

  // Pointer next-state
  always_comb begin
    feat_wr_d = feat_wr_q;
    feat_rd_d = feat_rd_q;
    ctx_wr_d  = ctx_wr_q;
    ctx_rd_d  = ctx_rd_q;
    if (feat_push) feat_wr_d = feat_wr_q + PW'(1);
    if (ctx_push)  ctx_wr_d  = ctx_wr_q + PW'(1);
    if (pair_load) begin
      feat_rd_d = feat_rd_q + PW'(1);
      ctx_rd_d  = ctx_rd_q + PW'(1);
    end
  end

  // Output register next-state: load beats drain; stall holds everything
  always_comb begin
    out_valid_d = out_valid_q;
    concat_d    = concat_q;
    if (pair_load) begin
      out_valid_d = 1'b1;
      concat_d    = (FEAT_HIGH != 0) ? {feat_head, ctx_head} : {ctx_head, feat_head};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_wr_q   <= '0;
      feat_rd_q   <= '0;
      ctx_wr_q    <= '0;
      ctx_rd_q    <= '0;
      out_valid_q <= 1'b0;
      concat_q    <= '0;
    end else begin
      feat_wr_q   <= feat_wr_d;
      feat_rd_q   <= feat_rd_d;
      ctx_wr_q    <= ctx_wr_d;
      ctx_rd_q    <= ctx_rd_d;
      out_valid_q <= out_valid_d;
      concat_q    <= concat_d;
    end
  end

  // FIFO data arrays; contents are don't-care while pointers say empty
  always_ff @(posedge clk) begin
    if (feat_push) feat_mem_q[feat_wr_q[AW-1:0]] <= feature;
    if (ctx_push)  ctx_mem_q[ctx_wr_q[AW-1:0]]   <= context2;
  end

`ifdef CONCAT_STREAM_STATS_EN
  logic [15:0] pair_count_q, pair_count_d;

  // Counts every output handshake, wrapping naturally at 16 bits
  always_comb begin
    pair_count_d = pair_count_q;
    if (out_valid_q && out_ready) pair_count_d = pair_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pair_count_q <= '0;
    else        pair_count_q <= pair_count_d;
  end

  assign pair_count = pair_count_q;
`endif

endmodule
